div_issue_ctrl: RTL and testbench

Sequencing and arbitration controller for the shared multi-cycle sequential divider. It picks one of NUM_REQ divide/remainder reservation-station requesters round-robin and pulses the divider start. It tracks the in-flight op's ROB tag and branch mask, and squashes it on branch misprediction recovery. It holds the finished result until the CDB arbiter grants a broadcast slot.

---
 rtl/div_issue_ctrl_if.sv | 36 +++
 rtl/div_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_div_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - request, divider, branch and CDB signal bundle for div_issue_ctrl
interface div_issue_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int BR_W    = 4
);
  localparam int BR_IDX_W = (BR_W > 1) ? $clog2(BR_W) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ*BR_W-1:0]  req_brmask;
  logic [NUM_REQ-1:0]       req_gnt;
  logic                     div_start;
  logic                     div_complete;
  logic [31:0]              div_result;
  logic                     br_valid;
  logic                     br_mispred;
  logic [BR_IDX_W-1:0]      br_idx;
  logic                     cdb_req;
  logic                     cdb_gnt;
  logic [TAG_W-1:0]         out_tag;
  logic [31:0]              out_data;
  logic                     busy;

  modport slave (
    input  req_valid, req_tag, req_brmask, div_complete, div_result,
           br_valid, br_mispred, br_idx, cdb_gnt,
    output req_gnt, div_start, cdb_req, out_tag, out_data, busy
  );

  modport master (
    output req_valid, req_tag, req_brmask, div_complete, div_result,
           br_valid, br_mispred, br_idx, cdb_gnt,
    input  req_gnt, div_start, cdb_req, out_tag, out_data, busy
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - round-robin issue, squash and CDB hold controller for the shared divider
module div_issue_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int BR_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  div_issue_ctrl_if.slave    bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, next_state;
  logic [PTR_W-1:0]   rr_ptr, cand_idx, next_ptr;
  logic [PTR_W:0]     sum;
  logic               cand_found, grant_en;
  logic               mispred, correct, kill_now;
  logic [NUM_REQ-1:0] eligible, gnt;
  logic [TAG_W-1:0]   held_tag, cand_tag;
  logic [BR_W-1:0]    held_mask, cand_mask;
  logic [31:0]        held_data;
  logic               killed;

  assign mispred  = bus.br_valid && bus.br_mispred;
  assign correct  = bus.br_valid && !bus.br_mispred;
  assign kill_now = mispred && held_mask[bus.br_idx];

  // A requester squashed by this cycle's mispredict is not eligible for grant
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_elig
      logic [BR_W-1:0] mask;
      assign mask        = bus.req_brmask[g*BR_W +: BR_W];
      assign eligible[g] = bus.req_valid[g] && !(mispred && mask[bus.br_idx]);
    end
  endgenerate

  // Pick the first eligible entry at or after rr_ptr, wrapping around
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    sum        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ))
        sum = sum - (PTR_W+1)'(NUM_REQ);
      if (!cand_found && eligible[sum[PTR_W-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = sum[PTR_W-1:0];
      end
    end
  end

  // Fetch tag and branch mask of the chosen candidate
  always_comb begin
    cand_tag  = '0;
    cand_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand_idx == PTR_W'(i)) begin
        cand_tag  = bus.req_tag[i*TAG_W +: TAG_W];
        cand_mask = bus.req_brmask[i*BR_W +: BR_W];
      end
    end
  end

  assign next_ptr = (cand_idx == PTR_W'(NUM_REQ-1)) ? '0 : cand_idx + PTR_W'(1);
  assign grant_en = (state == IDLE) && cand_found && !rst;
  assign gnt      = grant_en ? (NUM_REQ'(1) << cand_idx) : '0;

  // Next-state: issue from IDLE, wait out the divider, hold result until CDB or squash
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (grant_en) next_state = BUSY;
      BUSY: if (bus.div_complete) next_state = (killed || kill_now) ? IDLE : DONE;
      DONE: if (bus.cdb_gnt || kill_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Track the in-flight op: tag, live branch mask, squash flag and result
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      held_tag  <= '0;
      held_mask <= '0;
      held_data <= '0;
      killed    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_en) begin
            held_tag  <= cand_tag;
            held_mask <= cand_mask;
            killed    <= 1'b0;
            rr_ptr    <= next_ptr;
          end
        end
        BUSY: begin
          if (kill_now) killed <= 1'b1;
          if (correct) held_mask[bus.br_idx] <= 1'b0;
          if (bus.div_complete && !killed && !kill_now) held_data <= bus.div_result;
        end
        DONE: begin
          if (correct) held_mask[bus.br_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_gnt   = gnt;
  assign bus.div_start = grant_en;
  assign bus.cdb_req   = (state == DONE);
  assign bus.out_tag   = held_tag;
  assign bus.out_data  = held_data;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl
module tb_div_issue_ctrl;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int BR_W    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .BR_W(BR_W)) bus ();

  div_issue_ctrl #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .BR_W(BR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int idx; logic [TAG_W-1:0] tag; } gnt_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; } cdb_t;
  gnt_t gnt_q[$];
  cdb_t cdb_q[$];

  // reference model: 0 idle, 1 divider running, 2 result held
  int               m_state  = 0;
  int               m_ptr    = 0;
  logic [TAG_W-1:0] m_tag    = '0;
  logic [BR_W-1:0]  m_mask   = '0;
  logic [31:0]      m_data   = '0;
  bit               m_killed = 1'b0;

  bit               e_start, e_busy, e_cdb;
  logic [TAG_W-1:0] e_tag;
  logic [31:0]      e_data;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, derive this cycle's expected outputs, advance the model
  task automatic cycle(input bit r, input logic [NUM_REQ-1:0] rv,
                       input logic [NUM_REQ*TAG_W-1:0] tags, input logic [NUM_REQ*BR_W-1:0] masks,
                       input bit bv, input bit bm, input logic [1:0] bi,
                       input bit dc, input logic [31:0] dr, input bit cg);
    bit mis;
    bit kill;
    int i;
    mis  = bv && bm;
    kill = mis && m_mask[bi];
    // the CDB arbiter never grants a result that is being squashed
    if (m_state == 2 && kill) cg = 1'b0;

    rst                  = r;
    bus.req_valid        = rv;
    bus.req_tag          = tags;
    bus.req_brmask       = masks;
    bus.br_valid         = bv;
    bus.br_mispred       = bm;
    bus.br_idx           = bi;
    bus.div_complete     = dc;
    bus.div_result       = dr;
    bus.cdb_gnt          = cg;

    e_busy  = (m_state != 0);
    e_cdb   = (m_state == 2);
    e_tag   = m_tag;
    e_data  = m_data;
    e_start = 1'b0;

    case (m_state)
      0: if (!r) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          i = (m_ptr + k) % NUM_REQ;
          if (!e_start && rv[i] && !(mis && masks[i*BR_W + int'(bi)])) begin
            e_start  = 1'b1;
            gnt_q.push_back('{i, tags[i*TAG_W +: TAG_W]});
            m_tag    = tags[i*TAG_W +: TAG_W];
            m_mask   = masks[i*BR_W +: BR_W];
            m_killed = 1'b0;
            m_ptr    = (i + 1) % NUM_REQ;
            m_state  = 1;
          end
        end
      end
      1: begin
        if (kill) m_killed = 1'b1;
        if (bv && !bm) m_mask[bi] = 1'b0;
        if (dc) begin
          if (m_killed) m_state = 0;
          else begin
            m_data  = dr;
            m_state = 2;
          end
        end
      end
      default: begin
        if (cg) begin
          cdb_q.push_back('{m_tag, m_data});
          m_state = 0;
        end else if (kill) begin
          m_state = 0;
        end
        if (bv && !bm) m_mask[bi] = 1'b0;
      end
    endcase

    if (r) begin
      m_state  = 0;
      m_ptr    = 0;
      m_tag    = '0;
      m_mask   = '0;
      m_data   = '0;
      m_killed = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: level checks against the model plus scoreboard pops on grants and broadcasts
  always @(negedge clk) begin
    if (mon_en) begin
      check("div_start", 64'(bus.div_start), 64'(e_start));
      check("busy", 64'(bus.busy), 64'(e_busy));
      check("cdb_req", 64'(bus.cdb_req), 64'(e_cdb));
      check("out_tag", 64'(bus.out_tag), 64'(e_tag));
      check("out_data", 64'(bus.out_data), 64'(e_data));
      if (bus.req_gnt != '0) begin
        if (gnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %b expected none", bus.req_gnt);
        end else begin
          gnt_t g;
          g = gnt_q.pop_front();
          check("req_gnt", 64'(bus.req_gnt), 64'(1) << g.idx);
        end
      end
      if (bus.cdb_req && bus.cdb_gnt) begin
        if (cdb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_broadcast: got tag %0h expected none", bus.out_tag);
        end else begin
          cdb_t c;
          c = cdb_q.pop_front();
          check("cdb_tag", 64'(bus.out_tag), 64'(c.tag));
          check("cdb_data", 64'(bus.out_data), 64'(c.data));
        end
      end
    end
  end

  localparam logic [NUM_REQ*TAG_W-1:0] TAGS_E1_5 = (NUM_REQ*TAG_W)'(5) << TAG_W;
  localparam logic [NUM_REQ*TAG_W-1:0] TAGS_SEQ  = {6'd13, 6'd12, 6'd11, 6'd10};

  initial begin
    rst              = 1'b1;
    bus.req_valid    = '0;
    bus.req_tag      = '0;
    bus.req_brmask   = '0;
    bus.br_valid     = 1'b0;
    bus.br_mispred   = 1'b0;
    bus.br_idx       = '0;
    bus.div_complete = 1'b0;
    bus.div_result   = '0;
    bus.cdb_gnt      = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycle(1, '0, '0, '0, 0, 0, 0, 0, 0, 0);

    // single request on entry 1 with tag 5, result 7, then 10 cycles of back-pressure
    cycle(0, 4'b0010, TAGS_E1_5, '0, 0, 0, 0, 0, 0, 0);
    cycle(0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    cycle(0, '0, '0, '0, 0, 0, 0, 1, 32'h7, 0);
    for (int n = 0; n < 10; n++) cycle(0, 4'b1111, TAGS_SEQ, '0, 0, 0, 0, 0, 0, 0);
    cycle(0, 4'b1111, TAGS_SEQ, '0, 0, 0, 0, 0, 0, 1);

    // round robin with all entries requesting
    for (int op = 0; op < 4; op++) begin
      cycle(0, 4'b1111, TAGS_SEQ, '0, 0, 0, 0, 0, 0, 0);
      cycle(0, '0, '0, '0, 0, 0, 0, 1, 32'(100 + op), 0);
      cycle(0, '0, '0, '0, 0, 0, 0, 0, 0, 1);
    end

    // kill in BUSY: mask 0100 squashed by mispredict on idx 2, then a fresh grant
    cycle(0, 4'b0001, TAGS_SEQ, 16'h0004, 0, 0, 0, 0, 0, 0);
    cycle(0, '0, '0, '0, 1, 1, 2'd2, 0, 0, 0);
    cycle(0, '0, '0, '0, 0, 0, 0, 1, 32'hdead, 1);
    cycle(0, 4'b0010, TAGS_SEQ, '0, 0, 0, 0, 0, 0, 0);
    cycle(0, '0, '0, '0, 0, 0, 0, 1, 32'h55, 1);

    // correct prediction clears the bit so a later mispredict on idx 2 does not squash
    cycle(0, 4'b0100, TAGS_SEQ, 16'h0400, 0, 0, 0, 0, 0, 0);
    cycle(0, '0, '0, '0, 1, 0, 2'd2, 0, 0, 0);
    cycle(0, '0, '0, '0, 1, 1, 2'd2, 1, 32'h1234, 0);
    cycle(0, '0, '0, '0, 0, 0, 0, 0, 0, 1);

    // kill at grant: only requester's mask matches the mispredict
    cycle(0, 4'b1000, TAGS_SEQ, 16'h2000, 1, 1, 2'd1, 0, 0, 0);
    cycle(0, '0, '0, '0, 0, 0, 0, 0, 0, 0);

    // reset while BUSY, then a late completion
    cycle(0, 4'b1000, TAGS_SEQ, '0, 0, 0, 0, 0, 0, 0);
    cycle(1, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    cycle(0, '0, '0, '0, 0, 0, 0, 1, 32'hbeef, 1);
    cycle(0, '0, '0, '0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      cycle(r,
            r ? '0 : ($urandom_range(0, 1) ? NUM_REQ'($urandom) : '0),
            (NUM_REQ*TAG_W)'($urandom),
            (NUM_REQ*BR_W)'($urandom),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            2'($urandom),
            ($urandom_range(0, 3) == 0),
            $urandom,
            ($urandom_range(0, 3) == 0));
    end
    cycle(0, '0, '0, '0, 0, 0, 0, 1, 0, 1);
    cycle(0, '0, '0, '0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    mon_en = 1'b0;
    check("grant_queue_drained", 64'(gnt_q.size()), 64'(0));
    check("cdb_queue_drained", 64'(cdb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
